// File: rtl/scalar_tuple_checker_if.sv
// rtl/scalar_tuple_checker_if.sv - sample bundle and status bus between a tuple harness and its checker
//
// Signals:
//   start, sample_valid   run control and bundle strobe (harness -> checker)
//   in1..in10             scalar fields of the compiled tuple's output bundle
//   busy, done, pass      run status (checker -> harness)
//   sample_cnt            samples accepted in the current run
//   mismatch_cnt          samples with at least one bad field, saturating
//   fail_mask             sticky per-field failure bits (bit k-1 = field k)
//   first_fail_idx        lowest bad field of the first bad sample, 0 = none
interface scalar_tuple_checker_if;
  logic       start;
  logic       sample_valid;
  logic [2:0] in1;
  logic [3:0] in2;
  logic [3:0] in3;
  logic [3:0] in4;
  logic [2:0] in5;
  logic [2:0] in6;
  logic [1:0] in7;
  logic [1:0] in8;
  logic [2:0] in9;
  logic [2:0] in10;

  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] sample_cnt;
  logic [7:0] mismatch_cnt;
  logic [9:0] fail_mask;
  logic [3:0] first_fail_idx;

  modport master (
    output start, sample_valid,
    output in1, in2, in3, in4, in5, in6, in7, in8, in9, in10,
    input  busy, done, pass, sample_cnt, mismatch_cnt, fail_mask, first_fail_idx
  );

  modport slave (
    input  start, sample_valid,
    input  in1, in2, in3, in4, in5, in6, in7, in8, in9, in10,
    output busy, done, pass, sample_cnt, mismatch_cnt, fail_mask, first_fail_idx
  );
endinterface

// File: rtl/scalar_tuple_checker.sv
// rtl/scalar_tuple_checker.sv - checks a ten-field scalar bundle against constants over a run of samples
//
// Ports:
//   clock  rising-edge clock for all state
//   reset  synchronous, active-high; returns to IDLE with all outputs 0
//   bus    scalar_tuple_checker_if.slave: start/sample_valid/in1..in10 in,
//          busy/done/pass/sample_cnt/mismatch_cnt/fail_mask/first_fail_idx out
module scalar_tuple_checker #(
  parameter int NUM_SAMPLES = 16,
  parameter int EXP1  = 7,
  parameter int EXP2  = 8,
  parameter int EXP3  = 9,
  parameter int EXP4  = 10,
  parameter int EXP5  = 7,
  parameter int EXP6  = 6,
  parameter int EXP7  = 3,
  parameter int EXP8  = 3,
  parameter int EXP9  = 7,
  parameter int EXP10 = 5
) (
  input logic                   clock,
  input logic                   reset,
  scalar_tuple_checker_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Expected constants cut down to each field's width; comparisons are unsigned.
  localparam logic [2:0] E1  = 3'(EXP1);
  localparam logic [3:0] E2  = 4'(EXP2);
  localparam logic [3:0] E3  = 4'(EXP3);
  localparam logic [3:0] E4  = 4'(EXP4);
  localparam logic [2:0] E5  = 3'(EXP5);
  localparam logic [2:0] E6  = 3'(EXP6);
  localparam logic [1:0] E7  = 2'(EXP7);
  localparam logic [1:0] E8  = 2'(EXP8);
  localparam logic [2:0] E9  = 3'(EXP9);
  localparam logic [2:0] E10 = 3'(EXP10);

  // Count value held just before the final sample of a run is accepted.
  localparam logic [7:0] LAST_CNT = 8'(NUM_SAMPLES - 1);

  state_t     state_q, state_d;
  logic [7:0] sample_cnt_q, sample_cnt_d;
  logic [7:0] mismatch_cnt_q, mismatch_cnt_d;
  logic [9:0] fail_mask_q, fail_mask_d;
  logic [3:0] first_fail_q, first_fail_d;
  logic       busy_q, done_q, pass_q;

  logic [9:0] miss;
  logic [3:0] lowest_miss;

  always_comb begin
    miss = {
      bus.in10 != E10,
      bus.in9  != E9,
      bus.in8  != E8,
      bus.in7  != E7,
      bus.in6  != E6,
      bus.in5  != E5,
      bus.in4  != E4,
      bus.in3  != E3,
      bus.in2  != E2,
      bus.in1  != E1
    };
  end

  // Priority encode from the top down so the lowest set bit wins; result is 1-based.
  always_comb begin
    lowest_miss = 4'd0;
    for (int k = 9; k >= 0; k--) begin
      if (miss[k]) begin
        lowest_miss = 4'(k + 1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    sample_cnt_d   = sample_cnt_q;
    mismatch_cnt_d = mismatch_cnt_q;
    fail_mask_d    = fail_mask_q;
    first_fail_d   = first_fail_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d        = RUN;
          sample_cnt_d   = 8'd0;
          mismatch_cnt_d = 8'd0;
          fail_mask_d    = 10'd0;
          first_fail_d   = 4'd0;
        end
      end

      RUN: begin
        // start is deliberately not looked at here: a run cannot be restarted mid-way.
        if (bus.sample_valid) begin
          sample_cnt_d = sample_cnt_q + 8'd1;
          fail_mask_d  = fail_mask_q | miss;
          if (|miss) begin
            if (mismatch_cnt_q != 8'hFF) begin
              mismatch_cnt_d = mismatch_cnt_q + 8'd1;
            end
            if (first_fail_q == 4'd0) begin
              first_fail_d = lowest_miss;
            end
          end
          if (sample_cnt_q == LAST_CNT) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        // A sample arriving with the restart strobe belongs to no run and is dropped.
        if (bus.start) begin
          state_d        = RUN;
          sample_cnt_d   = 8'd0;
          mismatch_cnt_d = 8'd0;
          fail_mask_d    = 10'd0;
          first_fail_d   = 4'd0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status flags are registered from the next state so they line up with the counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      sample_cnt_q   <= 8'd0;
      mismatch_cnt_q <= 8'd0;
      fail_mask_q    <= 10'd0;
      first_fail_q   <= 4'd0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      pass_q         <= 1'b0;
    end else begin
      sample_cnt_q   <= sample_cnt_d;
      mismatch_cnt_q <= mismatch_cnt_d;
      fail_mask_q    <= fail_mask_d;
      first_fail_q   <= first_fail_d;
      busy_q         <= (state_d == RUN);
      done_q         <= (state_d == DONE);
      pass_q         <= (state_d == DONE) && (mismatch_cnt_d == 8'd0);
    end
  end

  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.pass           = pass_q;
  assign bus.sample_cnt     = sample_cnt_q;
  assign bus.mismatch_cnt   = mismatch_cnt_q;
  assign bus.fail_mask      = fail_mask_q;
  assign bus.first_fail_idx = first_fail_q;

endmodule

// File: tb/tb_scalar_tuple_checker.sv
// tb/tb_scalar_tuple_checker.sv - self-checking bench for scalar_tuple_checker (16- and 255-sample instances)
module tb_scalar_tuple_checker;

  localparam int EXP_V [10] = '{7, 8, 9, 10, 7, 6, 3, 3, 7, 5};
  localparam int WID_V [10] = '{3, 4, 4, 4, 3, 3, 2, 2, 3, 3};
  localparam int NUM_V [2]  = '{16, 255};

  logic       clock = 1'b0;
  logic       reset_r;
  logic       start_r;
  logic       sv_r;
  logic [3:0] vals [10];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  scalar_tuple_checker_if bus0 ();
  scalar_tuple_checker_if bus1 ();

  assign bus0.start = start_r;        assign bus1.start = start_r;
  assign bus0.sample_valid = sv_r;    assign bus1.sample_valid = sv_r;
  assign bus0.in1  = vals[0][2:0];    assign bus1.in1  = vals[0][2:0];
  assign bus0.in2  = vals[1];         assign bus1.in2  = vals[1];
  assign bus0.in3  = vals[2];         assign bus1.in3  = vals[2];
  assign bus0.in4  = vals[3];         assign bus1.in4  = vals[3];
  assign bus0.in5  = vals[4][2:0];    assign bus1.in5  = vals[4][2:0];
  assign bus0.in6  = vals[5][2:0];    assign bus1.in6  = vals[5][2:0];
  assign bus0.in7  = vals[6][1:0];    assign bus1.in7  = vals[6][1:0];
  assign bus0.in8  = vals[7][1:0];    assign bus1.in8  = vals[7][1:0];
  assign bus0.in9  = vals[8][2:0];    assign bus1.in9  = vals[8][2:0];
  assign bus0.in10 = vals[9][2:0];    assign bus1.in10 = vals[9][2:0];

  scalar_tuple_checker #(.NUM_SAMPLES(16)) dut16 (
    .clock (clock),
    .reset (reset_r),
    .bus   (bus0)
  );

  scalar_tuple_checker #(.NUM_SAMPLES(255)) dut255 (
    .clock (clock),
    .reset (reset_r),
    .bus   (bus1)
  );

  // Reference model: phase 0 idle, 1 running, 2 finished.
  int         m_ph    [2];
  int         m_cnt   [2];
  int         m_mis   [2];
  int         m_first [2];
  logic [9:0] m_mask  [2];

  function automatic logic [9:0] model_miss();
    logic [9:0] m;
    m = '0;
    for (int k = 0; k < 10; k++) begin
      if ((int'(vals[k]) % (1 << WID_V[k])) != (EXP_V[k] % (1 << WID_V[k]))) m[k] = 1'b1;
    end
    return m;
  endfunction

  function automatic int model_lowest(input logic [9:0] m);
    for (int k = 0; k < 10; k++) begin
      if (m[k]) return k + 1;
    end
    return 0;
  endfunction

  task automatic model_clear(input int d);
    m_cnt[d] = 0; m_mis[d] = 0; m_first[d] = 0; m_mask[d] = '0;
  endtask

  task automatic model_step(input int d);
    logic [9:0] m;
    if (reset_r) begin
      m_ph[d] = 0;
      model_clear(d);
    end else if (m_ph[d] == 1) begin
      if (sv_r) begin
        m = model_miss();
        m_cnt[d] = m_cnt[d] + 1;
        m_mask[d] = m_mask[d] | m;
        if (m != 0) begin
          if (m_mis[d] < 255) m_mis[d] = m_mis[d] + 1;
          if (m_first[d] == 0) m_first[d] = model_lowest(m);
        end
        if (m_cnt[d] == NUM_V[d]) m_ph[d] = 2;
      end
    end else if (start_r) begin
      m_ph[d] = 1;
      model_clear(d);
    end
  endtask

  always @(posedge clock) begin
    model_step(0);
    model_step(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [63:0] model_pack(input int d);
    return {31'd0, m_ph[d] == 1, m_ph[d] == 2, (m_ph[d] == 2) && (m_mis[d] == 0),
            8'(m_cnt[d]), 8'(m_mis[d]), m_mask[d], 4'(m_first[d])};
  endfunction

  logic [63:0] act0, act1;
  assign act0 = {31'd0, bus0.busy, bus0.done, bus0.pass, bus0.sample_cnt, bus0.mismatch_cnt,
                 bus0.fail_mask, bus0.first_fail_idx};
  assign act1 = {31'd0, bus1.busy, bus1.done, bus1.pass, bus1.sample_cnt, bus1.mismatch_cnt,
                 bus1.fail_mask, bus1.first_fail_idx};

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    check("cycle_dut16", act0, model_pack(0));
    check("cycle_dut255", act1, model_pack(1));
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_golden();
    for (int k = 0; k < 10; k++) vals[k] = 4'(EXP_V[k]);
  endtask

  initial begin
    int driven;
    int cyc;
    reset_r = 1'b1; start_r = 1'b0; sv_r = 1'b0;
    set_golden();
    tick(); tick();
    reset_r = 1'b0;
    @(negedge clock);
    check("reset_state", act0, 64'd0);

    // sample_valid while idle is ignored
    sv_r = 1'b1;
    tick(); tick(); tick();
    sv_r = 1'b0;
    @(negedge clock);
    check("idle_sv_cnt", 64'(bus0.sample_cnt), 64'd0);
    check("idle_sv_busy", 64'(bus0.busy), 64'd0);

    // golden run
    start_r = 1'b1; tick(); start_r = 1'b0;
    sv_r = 1'b1;
    repeat (15) tick();
    @(negedge clock);
    check("done_not_early", 64'(bus0.done), 64'd0);
    tick();
    sv_r = 1'b0;
    @(negedge clock);
    check("golden_done", 64'(bus0.done), 64'd1);
    check("golden_pass", 64'(bus0.pass), 64'd1);
    check("golden_cnt", 64'(bus0.sample_cnt), 64'd16);
    check("golden_stats", 64'({bus0.mismatch_cnt, bus0.fail_mask, bus0.first_fail_idx}), 64'd0);

    // sample 3 fails fields 4 and 9
    start_r = 1'b1; tick(); start_r = 1'b0;
    sv_r = 1'b1;
    for (int i = 0; i < 16; i++) begin
      set_golden();
      if (i == 2) begin vals[3] = 4'd11; vals[8] = 4'd6; end
      tick();
    end
    sv_r = 1'b0; set_golden();
    @(negedge clock);
    check("t2_mis", 64'(bus0.mismatch_cnt), 64'd1);
    check("t2_mask", 64'(bus0.fail_mask), 64'b01_0000_1000);
    check("t2_first", 64'(bus0.first_fail_idx), 64'd4);
    check("t2_pass", 64'({bus0.done, bus0.pass}), 64'b10);

    // sample 2 fails field 10, sample 5 fails field 1
    start_r = 1'b1; tick(); start_r = 1'b0;
    sv_r = 1'b1;
    for (int i = 0; i < 16; i++) begin
      set_golden();
      if (i == 1) vals[9] = 4'd4;
      if (i == 4) vals[0] = 4'd0;
      tick();
    end
    sv_r = 1'b0; set_golden();
    @(negedge clock);
    check("t3_first", 64'(bus0.first_fail_idx), 64'd10);
    check("t3_mask", 64'(bus0.fail_mask), 64'b10_0000_0001);
    check("t3_mis", 64'(bus0.mismatch_cnt), 64'd2);

    // 255-sample run, field 2 always bad, gap every third cycle
    reset_r = 1'b1; tick(); reset_r = 1'b0;
    start_r = 1'b1; tick(); start_r = 1'b0;
    driven = 0; cyc = 0;
    while (driven < 255 && cyc < 1000) begin
      set_golden(); vals[1] = 4'd0;
      sv_r = (cyc % 3) != 2;
      tick();
      if (sv_r) driven++;
      cyc++;
    end
    sv_r = 1'b0; set_golden();
    @(negedge clock);
    check("t4_cnt", 64'(bus1.sample_cnt), 64'd255);
    check("t4_mis_sat", 64'(bus1.mismatch_cnt), 64'd255);
    check("t4_busy_done", 64'({bus1.busy, bus1.done, bus1.pass}), 64'b010);
    check("t4_first", 64'({bus1.fail_mask, bus1.first_fail_idx}), 64'({10'b00_0000_0010, 4'd2}));

    // reset mid-run, then a clean run with ignored start pulses
    start_r = 1'b1; tick(); start_r = 1'b0;
    sv_r = 1'b1; repeat (7) tick(); sv_r = 1'b0;
    reset_r = 1'b1; tick(); reset_r = 1'b0;
    @(negedge clock);
    check("t5_abort16", act0, 64'd0);
    check("t5_abort255", act1, 64'd0);
    start_r = 1'b1; tick(); start_r = 1'b0;
    sv_r = 1'b1;
    for (int i = 0; i < 16; i++) begin
      start_r = (i == 4 || i == 9);
      tick();
    end
    start_r = 1'b0; sv_r = 1'b0;
    @(negedge clock);
    check("t5_pass", 64'({bus0.done, bus0.pass}), 64'b11);
    check("t5_cnt", 64'(bus0.sample_cnt), 64'd16);

    // restart from DONE with a coincident sample
    start_r = 1'b1; sv_r = 1'b1; tick(); start_r = 1'b0; sv_r = 1'b0;
    @(negedge clock);
    check("t6_restart_busy", 64'(bus0.busy), 64'd1);
    check("t6_restart_cnt", 64'(bus0.sample_cnt), 64'd0);

    tick(); tick();
    @(negedge clock);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
